imem_server: RTL
================

IMEM_SERVER -- requirements
Module: imem_server

Interface
REQ-001 Parameter ADDR_W, default 13: word-address width; memory depth is 2^ADDR_W words.
REQ-002 Parameter DATA_W, default 32: instruction word width.
REQ-003 clk  in  1  single clock; all state changes on its rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 ld_we  in  1  loader write strobe; honoured in LOAD only.
REQ-006 ld_addr  in  ADDR_W  loader word address.
REQ-007 ld_data  in  DATA_W  loader instruction word.
REQ-008 start  in  1  single-cycle pulse that ends loading and begins fetch service.
REQ-009 pc_in  in  15  CPU byte address; the word index is pc_in[14:2].
REQ-010 ir_out  out  DATA_W  instruction returned to the CPU.
REQ-011 ir_valid  out  1  ir_out holds a fetched in-program instruction.
REQ-012 halted  out  1  program end reached; fetch service stopped.
REQ-013 err  out  1  halt caused by a misaligned pc_in (only when IMEM_ALIGN_CHECK_EN is defined).
REQ-014 prog_len  out  ADDR_W+1  loaded program length in words.
REQ-015 fetch_cnt  out  16  count of instructions delivered.

Function
REQ-016 The FSM SHALL have three states: LOAD, RUN and HALT. LOAD is the reset state.
REQ-017 In LOAD, each cycle with ld_we=1 SHALL write mem[ld_addr]<=ld_data and set prog_len<=max(prog_len, ld_addr+1).
REQ-018 When ld_we and start are asserted in the same LOAD cycle, the SHALL commit the write and compute the RUN/HALT decision from the updated prog_len.
REQ-019 On start in LOAD, the FSM SHALL go to RUN if the (updated) prog_len is nonzero, otherwise to HALT.
REQ-020 In RUN, ld_we and start SHALL be ignored, and memory and prog_len SHALL NOT change.
REQ-021 In RUN, if pc_in[14:2] < prog_len, the block SHALL register ir_out<=mem[pc_in[14:2]] and ir_valid<=1 at the next edge (latency 1 cycle), and increment fetch_cnt.
REQ-022 In RUN, if pc_in[14:2] >= prog_len, then at the next edge the block SHALL set ir_out<=0, ir_valid<=0, halted<=1 and move to HALT; fetch_cnt SHALL NOT change.
REQ-023 fetch_cnt SHALL saturate at 16'hFFFF and SHALL NOT wrap.
REQ-024 HALT SHALL be terminal until rst: ir_out=0, ir_valid=0, halted=1, and all inputs are ignored.
REQ-025 In LOAD, ir_out=0 and ir_valid=0 regardless of pc_in.
REQ-026 Memory contents SHALL be undefined after power-up and SHALL be neither cleared nor read during LOAD.
REQ-027 A write to ld_addr = 2^ADDR_W-1 SHALL set prog_len to 2^ADDR_W with no overflow.

Reset
REQ-028 rst SHALL asynchronously force state=LOAD, ir_out=0, ir_valid=0, halted=0, err=0, prog_len=0 and fetch_cnt=0.
REQ-029 rst asserted mid-RUN SHALL abort the fetch in progress; no ir_valid pulse SHALL appear after rst rises.
REQ-030 Memory contents SHALL NOT be modified by rst.

Configuration
REQ-031 The macro IMEM_ALIGN_CHECK_EN SHALL control alignment checking.
REQ-032 With IMEM_ALIGN_CHECK_EN defined, pc_in[1:0]!=0 in RUN SHALL take the REQ-022 halt path, additionally setting err<=1. This check takes priority over the length check.
REQ-033 With IMEM_ALIGN_CHECK_EN undefined, pc_in[1:0] SHALL be ignored and err SHALL be tied to 0.

Verification
REQ-034 Load words 0..2 = 32'h8C010004, 32'h00221820, 32'hAC030008, then pulse start. Drive pc_in=0,4,8 on consecutive cycles -> ir_out follows one cycle later in the same order, ir_valid=1, fetch_cnt=3.
REQ-035 Continuing REQ-034, drive pc_in=12 -> next edge: ir_valid=0, halted=1, ir_out=0, fetch_cnt stays 3. Later ld_we or start -> no change.
REQ-036 Pulse start with no loads -> HALT on the next edge, prog_len=0, halted=1.
REQ-037 Assert ld_we at ld_addr=5 and start in the same cycle -> prog_len=6, state RUN. pc_in=20 returns the written word.
REQ-038 With IMEM_ALIGN_CHECK_EN defined, drive pc_in=2 in RUN -> halted=1, err=1. With it undefined, the same stimulus returns mem[0] with err=0.
REQ-039 Assert rst during RUN between fetches -> outputs clear immediately, state LOAD. After reload and start, word 0 is still readable without being rewritten.

Source files
------------

// File: rtl/imem_server_if.sv
// Loader/CPU-facing bus of the instruction memory server.
// master: the loader/CPU side driving requests; slave: the memory server.
interface imem_server_if #(
    parameter int unsigned ADDR_W = 13,
    parameter int unsigned DATA_W = 32
);
    logic              ld_we;
    logic [ADDR_W-1:0] ld_addr;
    logic [DATA_W-1:0] ld_data;
    logic              start;
    logic [14:0]       pc_in;
    logic [DATA_W-1:0] ir_out;
    logic              ir_valid;
    logic              halted;
    logic              err;
    logic [ADDR_W:0]   prog_len;
    logic [15:0]       fetch_cnt;

    modport master (
        output ld_we, ld_addr, ld_data, start, pc_in,
        input  ir_out, ir_valid, halted, err, prog_len, fetch_cnt
    );

    modport slave (
        input  ld_we, ld_addr, ld_data, start, pc_in,
        output ir_out, ir_valid, halted, err, prog_len, fetch_cnt
    );
endinterface

// File: rtl/imem_server.sv
// Instruction memory server: a loader fills the memory, start switches to serving CPU
// fetches, and the first out-of-program fetch halts the block until reset.
// Optional feature: define IMEM_ALIGN_CHECK_EN to halt with err on a misaligned pc_in.
// ADDR_W is expected to be at most 13 (pc_in carries a 13-bit word index).
module imem_server #(
    parameter int unsigned ADDR_W = 13,
    parameter int unsigned DATA_W = 32
) (
    input logic          clk,
    input logic          rst,
    imem_server_if.slave bus
);
    localparam int unsigned LenW = ADDR_W + 1;

    typedef enum logic [1:0] {StLoad, StRun, StHalt} state_e;

    state_e            state_q;
    logic [DATA_W-1:0] ir_out_q;
    logic              ir_valid_q;
    logic              halted_q;
    logic [LenW-1:0]   prog_len_q;
    logic [LenW-1:0]   prog_len_d;
    logic [15:0]       fetch_cnt_q;
    logic [LenW-1:0]   wr_len;
    logic [12:0]       pc_word;
    logic              in_range;
    logic              misaligned;

    // Deliberately unreset: contents survive rst and are undefined at power-up.
    logic [DATA_W-1:0] mem [2**ADDR_W];

    // Program length as it stands after this cycle's loader write (if any).
    always_comb begin
        wr_len     = {1'b0, bus.ld_addr} + LenW'(1);
        prog_len_d = prog_len_q;
        if (bus.ld_we && (wr_len > prog_len_q)) begin
            prog_len_d = wr_len;
        end
    end

    // Fetch address decode: word index, in-program test and optional alignment test.
    always_comb begin
        pc_word  = bus.pc_in[14:2];
        in_range = 32'(pc_word) < 32'(prog_len_q);
`ifdef IMEM_ALIGN_CHECK_EN
        misaligned = |bus.pc_in[1:0];
`else
        misaligned = 1'b0;
`endif
    end

`ifndef IMEM_ALIGN_CHECK_EN
    logic unused_pc_lsb;
    assign unused_pc_lsb = ^bus.pc_in[1:0];
`endif

    // Loader writes land only while loading.
    always_ff @(posedge clk) begin
        if (state_q == StLoad && bus.ld_we) begin
            mem[bus.ld_addr] <= bus.ld_data;
        end
    end

`ifdef IMEM_ALIGN_CHECK_EN
    logic err_q;
`endif

    // Control FSM with all outputs registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StLoad;
            ir_out_q    <= '0;
            ir_valid_q  <= 1'b0;
            halted_q    <= 1'b0;
            prog_len_q  <= '0;
            fetch_cnt_q <= '0;
`ifdef IMEM_ALIGN_CHECK_EN
            err_q       <= 1'b0;
`endif
        end else begin
            case (state_q)
                StLoad: begin
                    ir_out_q   <= '0;
                    ir_valid_q <= 1'b0;
                    prog_len_q <= prog_len_d;
                    // Decision uses the length including a same-cycle write.
                    if (bus.start) begin
                        if (prog_len_d != '0) begin
                            state_q <= StRun;
                        end else begin
                            state_q  <= StHalt;
                            halted_q <= 1'b1;
                        end
                    end
                end
                StRun: begin
                    if (misaligned || !in_range) begin
                        state_q    <= StHalt;
                        ir_out_q   <= '0;
                        ir_valid_q <= 1'b0;
                        halted_q   <= 1'b1;
`ifdef IMEM_ALIGN_CHECK_EN
                        err_q      <= misaligned;
`endif
                    end else begin
                        ir_out_q   <= mem[ADDR_W'(pc_word)];
                        ir_valid_q <= 1'b1;
                        if (fetch_cnt_q != 16'hFFFF) begin
                            fetch_cnt_q <= fetch_cnt_q + 16'd1;
                        end
                    end
                end
                StHalt: begin
                    ir_out_q   <= '0;
                    ir_valid_q <= 1'b0;
                    halted_q   <= 1'b1;
                end
                default: begin
                    state_q <= StLoad;
                end
            endcase
        end
    end

    assign bus.ir_out    = ir_out_q;
    assign bus.ir_valid  = ir_valid_q;
    assign bus.halted    = halted_q;
    assign bus.prog_len  = prog_len_q;
    assign bus.fetch_cnt = fetch_cnt_q;
`ifdef IMEM_ALIGN_CHECK_EN
    assign bus.err       = err_q;
`else
    assign bus.err       = 1'b0;
`endif

endmodule
